mmio_responder: RTL and testbench

//  Memory-mapped I/O responder on the CPU data-memory bus: the target side of the CPU's en/we/re/addr/data interface.

---
 rtl/mmio_pkg.sv | 22 ++
 rtl/mmio_timer.sv | 54 +++++
 rtl/mmio_responder.sv | 128 ++++++++++++
 tb/tb_mmio_responder.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared register map and field widths for the MMIO responder.
package mmio_pkg;

    localparam logic [3:0] OFF_LED    = 4'h0;
    localparam logic [3:0] OFF_SW     = 4'h1;
    localparam logic [3:0] OFF_BTN    = 4'h2;
    localparam logic [3:0] OFF_BTNEVT = 4'h3;
    localparam logic [3:0] OFF_TMRLO  = 4'h4;
    localparam logic [3:0] OFF_TMRHI  = 4'h5;
    localparam logic [3:0] OFF_CMP    = 4'h6;
    localparam logic [3:0] OFF_STATUS = 4'h7;

    localparam int unsigned ST_MATCH = 0;
    localparam int unsigned ST_BTN   = 1;

    localparam int unsigned SW_W  = 8;
    localparam int unsigned BTN_W = 5;
    localparam int unsigned LED_W = 8;
    localparam int unsigned TMR_W = 18;
    localparam int unsigned CMP_W = 9;

endpackage

// File: rtl/mmio_timer.sv
// Prescaled 18-bit free-running timer with a 9-bit compare register and sticky match flag.
module mmio_timer
    import mmio_pkg::*;
#(
    parameter int unsigned g_PRESCALE = 100
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cmp_we,
    input  logic [CMP_W-1:0] i_cmp_wdata,
    input  logic             i_match_clr,
    output logic [TMR_W-1:0] o_timer,
    output logic [CMP_W-1:0] o_cmp,
    output logic             o_match
);

    localparam int unsigned      PRE_W    = (g_PRESCALE > 1) ? $clog2(g_PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(g_PRESCALE - 1);

    logic [PRE_W-1:0] r_pre;
    logic [TMR_W-1:0] r_timer;
    logic [CMP_W-1:0] r_cmp;
    logic             r_match;
    logic             w_tick;
    logic [TMR_W-1:0] w_timer_nxt;

    assign w_tick      = (r_pre == PRE_LAST);
    assign w_timer_nxt = r_timer + TMR_W'(1);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_pre   <= '0;
            r_timer <= '0;
            r_cmp   <= '0;
            r_match <= 1'b0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
            if (w_tick) begin
                r_timer <= w_timer_nxt;
            end
            if (i_cmp_we) begin
                r_cmp <= i_cmp_wdata;
            end
            // compare against the value the timer is about to take; a new match beats a clear
            r_match <= (r_match & ~i_match_clr) |
                       (w_tick & (w_timer_nxt[CMP_W-1:0] == r_cmp));
        end
    end

    assign o_timer = r_timer;
    assign o_cmp   = r_cmp;
    assign o_match = r_match;

endmodule

// File: rtl/mmio_responder.sv
// Memory-mapped I/O target on the CPU data bus: LEDs, synchronised switches/buttons with
// sticky edge events, and a prescaled timer with atomic LO/HI readout.
module mmio_responder
    import mmio_pkg::*;
#(
    parameter int unsigned                g_DATA_WIDTH = 9,
    parameter int unsigned                g_ADDR_WIDTH = 11,
    parameter logic [g_ADDR_WIDTH-1:0]    g_BASE       = 11'h7F0,
    parameter int unsigned                g_PRESCALE   = 100,
    parameter logic [LED_W-1:0]           g_LED_RST    = 8'h99
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic                    i_we,
    input  logic                    i_re,
    input  logic [g_ADDR_WIDTH-1:0] i_addr,
    input  logic [g_DATA_WIDTH-1:0] i_data,
    output logic [g_DATA_WIDTH-1:0] o_data,
    output logic                    o_rd_valid,
    input  logic [SW_W-1:0]         i_sw,
    input  logic [BTN_W-1:0]        i_btn,
    output logic [LED_W-1:0]        o_led
);

    logic                    w_hit;
    logic                    w_wr;
    logic                    w_rd;
    logic [3:0]              w_off;
    logic [BTN_W-1:0]        w_rise;
    logic [BTN_W-1:0]        w_evt_clr;
    logic                    w_match_clr;
    logic                    w_cmp_we;
    logic [TMR_W-1:0]        w_timer;
    logic [CMP_W-1:0]        w_cmp;
    logic                    w_match;
    logic [g_DATA_WIDTH-1:0] w_rdata;

    logic [SW_W-1:0]         r_sw_m;
    logic [SW_W-1:0]         r_sw_s;
    logic [BTN_W-1:0]        r_btn_m;
    logic [BTN_W-1:0]        r_btn_s;
    logic [BTN_W-1:0]        r_btn_prev;
    logic [BTN_W-1:0]        r_btn_evt;
    logic [LED_W-1:0]        r_led;
    logic [TMR_W-CMP_W-1:0]  r_shadow;
    logic [g_DATA_WIDTH-1:0] r_data;
    logic                    r_rd_valid;

    assign w_hit = i_en && (i_addr[g_ADDR_WIDTH-1:4] == g_BASE[g_ADDR_WIDTH-1:4]);
    assign w_wr  = w_hit && i_we;
    assign w_rd  = w_hit && i_re;
    assign w_off = i_addr[3:0];

    assign w_rise      = r_btn_s & ~r_btn_prev;
    assign w_evt_clr   = (w_wr && (w_off == OFF_BTNEVT)) ? i_data[BTN_W-1:0] : '0;
    assign w_match_clr = w_wr && (w_off == OFF_STATUS) && i_data[ST_MATCH];
    assign w_cmp_we    = w_wr && (w_off == OFF_CMP);

    mmio_timer #(
        .g_PRESCALE (g_PRESCALE)
    ) u_timer (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_cmp_we    (w_cmp_we),
        .i_cmp_wdata (i_data[CMP_W-1:0]),
        .i_match_clr (w_match_clr),
        .o_timer     (w_timer),
        .o_cmp       (w_cmp),
        .o_match     (w_match)
    );

    always_comb begin
        w_rdata = '0;
        case (w_off)
            OFF_LED:    w_rdata[LED_W-1:0] = r_led;
            OFF_SW:     w_rdata[SW_W-1:0]  = r_sw_s;
            OFF_BTN:    w_rdata[BTN_W-1:0] = r_btn_s;
            OFF_BTNEVT: w_rdata[BTN_W-1:0] = r_btn_evt;
            OFF_TMRLO:  w_rdata[CMP_W-1:0] = w_timer[CMP_W-1:0];
            OFF_TMRHI:  w_rdata[CMP_W-1:0] = r_shadow;
            OFF_CMP:    w_rdata[CMP_W-1:0] = w_cmp;
            OFF_STATUS: begin
                w_rdata[ST_MATCH] = w_match;
                w_rdata[ST_BTN]   = |r_btn_evt;
            end
            default:    w_rdata = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_sw_m     <= '0;
            r_sw_s     <= '0;
            r_btn_m    <= '0;
            r_btn_s    <= '0;
            r_btn_prev <= '0;
            r_btn_evt  <= '0;
            r_led      <= g_LED_RST;
            r_shadow   <= '0;
            r_data     <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_sw_m     <= i_sw;
            r_sw_s     <= r_sw_m;
            r_btn_m    <= i_btn;
            r_btn_s    <= r_btn_m;
            r_btn_prev <= r_btn_s;
            r_btn_evt  <= (r_btn_evt & ~w_evt_clr) | w_rise;
            if (w_wr && (w_off == OFF_LED)) begin
                r_led <= i_data[LED_W-1:0];
            end
            // latching the upper half on a LO read makes LO-then-HI an atomic 18-bit sample
            if (w_rd && (w_off == OFF_TMRLO)) begin
                r_shadow <= w_timer[TMR_W-1:CMP_W];
            end
            r_rd_valid <= w_rd;
            if (w_rd) begin
                r_data <= w_rdata;
            end
        end
    end

    assign o_data     = r_data;
    assign o_rd_valid = r_rd_valid;
    assign o_led      = r_led;

endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder against a cycle-count based behavioural model.
module tb_mmio_responder;

    localparam int unsigned P = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0, we = 1'b0, re = 1'b0;
    logic [10:0] addr = '0;
    logic [8:0]  data = '0;
    logic [7:0]  sw = '0;
    logic [4:0]  btn = '0;
    logic [8:0]  o_data;
    logic        o_rd_valid;
    logic [7:0]  o_led;

    int n_tests = 0;
    int n_fail  = 0;

    mmio_responder #(
        .g_PRESCALE (P)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_en       (en),
        .i_we       (we),
        .i_re       (re),
        .i_addr     (addr),
        .i_data     (data),
        .o_data     (o_data),
        .o_rd_valid (o_rd_valid),
        .i_sw       (sw),
        .i_btn      (btn),
        .o_led      (o_led)
    );

    always #5 clk = ~clk;

    // Model: timer value is derived purely from the number of clock edges since reset.
    int unsigned m_cyc;
    logic [7:0]  m_led;
    logic [8:0]  m_cmp;
    logic [4:0]  m_evt;
    logic        m_match;
    logic [8:0]  m_shadow;
    logic [8:0]  m_data;
    logic        m_valid;
    logic [4:0]  m_bh [0:3];
    logic [7:0]  m_sh [0:2];

    task automatic model_reset();
        m_cyc = 0; m_led = 8'h99; m_cmp = '0; m_evt = '0; m_match = 1'b0;
        m_shadow = '0; m_data = '0; m_valid = 1'b0;
        for (int i = 0; i < 4; i++) m_bh[i] = '0;
        for (int i = 0; i < 3; i++) m_sh[i] = '0;
    endtask

    task automatic bus(input logic e, input logic w, input logic r,
                       input logic [10:0] a, input logic [8:0] d);
        en = e; we = w; re = r; addr = a; data = d;
    endtask

    // One clock edge with the currently driven inputs; returns at the following negedge.
    task automatic step();
        logic        hit, rd, wr;
        logic [3:0]  off;
        logic [17:0] pre_t, new_t;
        logic        tick;
        logic [4:0]  rise;
        logic [8:0]  rv;
        logic [8:0]  cmp_pre;
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            for (int i = 3; i > 0; i--) m_bh[i] = m_bh[i-1];
            m_bh[0] = btn;
            for (int i = 2; i > 0; i--) m_sh[i] = m_sh[i-1];
            m_sh[0] = sw;
            m_cyc++;
            pre_t   = 18'((m_cyc - 1) / P);
            new_t   = 18'(m_cyc / P);
            tick    = (m_cyc % P) == 0;
            rise    = m_bh[2] & ~m_bh[3];
            hit     = en && (addr[10:4] == 7'h7F);
            rd      = hit && re;
            wr      = hit && we;
            off     = addr[3:0];
            cmp_pre = m_cmp;
            case (off)
                4'h0: rv = {1'b0, m_led};
                4'h1: rv = {1'b0, m_sh[2]};
                4'h2: rv = {4'b0, m_bh[2]};
                4'h3: rv = {4'b0, m_evt};
                4'h4: rv = pre_t[8:0];
                4'h5: rv = m_shadow;
                4'h6: rv = m_cmp;
                4'h7: rv = {7'b0, |m_evt, m_match};
                default: rv = '0;
            endcase
            m_valid = rd;
            if (rd) begin
                m_data = rv;
                if (off == 4'h4) m_shadow = pre_t[17:9];
            end
            m_match = (m_match & ~(wr && off == 4'h7 && data[0])) |
                      (tick && new_t[8:0] == cmp_pre);
            m_evt = (m_evt & ~((wr && off == 4'h3) ? data[4:0] : 5'h0)) | rise;
            if (wr && off == 4'h0) m_led = data[7:0];
            if (wr && off == 4'h6) m_cmp = data;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus(0, 0, 0, '0, '0);
        rst = 1'b0;
        model_reset();
        step(); step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (o_led !== 8'h99) begin n_fail++; $display("FAIL reset_led: got %h exp 99", o_led); end
        n_tests++;
        if (o_rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", o_rd_valid); end
        bus(1, 0, 1, 11'h7F6, '0); step();
        n_tests++;
        if (o_rd_valid !== 1'b1 || o_data !== 9'h000)
            begin n_fail++; $display("FAIL reset_cmp_read: got v=%b d=%h exp v=1 d=000", o_rd_valid, o_data); end
        bus(0, 0, 0, '0, '0); step();
        n_tests++;
        if (o_rd_valid !== 1'b0) begin n_fail++; $display("FAIL valid_pulse: got %b exp 0", o_rd_valid); end
    endtask

    task automatic test_led();
        bus(1, 1, 0, 11'h7F0, 9'h1A5); step();
        n_tests++;
        if (o_led !== 8'hA5) begin n_fail++; $display("FAIL led_write: got %h exp a5", o_led); end
        bus(1, 0, 1, 11'h7F0, '0); step();
        n_tests++;
        if (o_rd_valid !== 1'b1 || o_data !== 9'h0A5)
            begin n_fail++; $display("FAIL led_read: got v=%b d=%h exp v=1 d=0a5", o_rd_valid, o_data); end
        bus(1, 1, 1, 11'h7E0, 9'h0FF); step();
        n_tests++;
        if (o_rd_valid !== 1'b0 || o_data !== 9'h0A5 || o_led !== 8'hA5)
            begin n_fail++; $display("FAIL miss: got v=%b d=%h led=%h exp v=0 d=0a5 led=a5", o_rd_valid, o_data, o_led); end
        bus(0, 0, 0, '0, '0); step();
    endtask

    task automatic test_btn_evt();
        btn = 5'h04; step();
        btn = 5'h00; step(); step(); step();
        bus(1, 0, 1, 11'h7F3, '0); step();
        n_tests++;
        if (o_data !== 9'h004 || o_data !== m_data)
            begin n_fail++; $display("FAIL btnevt_set: got %h exp 004", o_data); end
        bus(1, 0, 1, 11'h7F7, '0); step();
        n_tests++;
        if (o_data[1] !== 1'b1 || o_data !== m_data)
            begin n_fail++; $display("FAIL status_btn: got %h exp %h", o_data, m_data); end
        bus(1, 1, 0, 11'h7F3, 9'h004); step();
        bus(1, 0, 1, 11'h7F3, '0); step();
        n_tests++;
        if (o_data !== 9'h000) begin n_fail++; $display("FAIL btnevt_clr: got %h exp 000", o_data); end
        bus(0, 0, 0, '0, '0);
        btn = 5'h04; step();
        btn = 5'h00; step();
        bus(1, 1, 0, 11'h7F3, 9'h004); step();
        bus(1, 0, 1, 11'h7F3, '0); step();
        n_tests++;
        if (o_data !== 9'h004 || o_data !== m_data)
            begin n_fail++; $display("FAIL btnevt_set_wins: got %h exp 004", o_data); end
        bus(1, 1, 0, 11'h7F3, 9'h01F); step();
        bus(0, 0, 0, '0, '0); step();
    endtask

    task automatic test_rw_same();
        bus(1, 1, 1, 11'h7F0, 9'h05A); step();
        n_tests++;
        if (o_data !== 9'h0A5 || o_led !== 8'h5A)
            begin n_fail++; $display("FAIL rw_same: got d=%h led=%h exp d=0a5 led=5a", o_data, o_led); end
        bus(0, 0, 0, '0, '0); step();
    endtask

    task automatic test_back_to_back();
        for (int o = 0; o < 8; o++) begin
            bus(1, 0, 1, {7'h7F, 4'(o)}, '0); step();
            n_tests++;
            if (o_rd_valid !== 1'b1 || o_data !== m_data)
                begin n_fail++; $display("FAIL b2b_off%0d: got v=%b d=%h exp v=1 d=%h", o, o_rd_valid, o_data, m_data); end
        end
        bus(0, 0, 0, '0, '0); step();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic [10:0] a;
            if ($urandom_range(0, 9) < 8) a = {7'h7F, 4'($urandom)};
            else a = 11'($urandom);
            bus(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), a, 9'($urandom));
            if ($urandom_range(0, 9) == 0) sw = 8'($urandom);
            if ($urandom_range(0, 5) == 0) btn = 5'($urandom);
            step();
            n_tests++;
            if (o_rd_valid !== m_valid || o_data !== m_data || o_led !== m_led) begin
                n_fail++;
                $display("FAIL random_%0d: got v=%b d=%h led=%h exp v=%b d=%h led=%h",
                         n, o_rd_valid, o_data, o_led, m_valid, m_data, m_led);
            end
        end
        bus(0, 0, 0, '0, '0); btn = '0; sw = '0; step();
    endtask

    task automatic test_match();
        do_reset();
        bus(1, 1, 0, 11'h7F6, 9'h003); step();
        bus(0, 0, 0, '0, '0);
        for (int i = 0; i < 10; i++) step();
        bus(1, 0, 1, 11'h7F7, '0); step();
        n_tests++;
        if (o_data !== 9'h000) begin n_fail++; $display("FAIL match_early: got %h exp 000", o_data); end
        step();
        n_tests++;
        if (o_data !== 9'h001 || o_data !== m_data)
            begin n_fail++; $display("FAIL match_set: got %h exp 001", o_data); end
        bus(1, 1, 0, 11'h7F7, 9'h001); step();
        bus(1, 0, 1, 11'h7F7, '0); step();
        n_tests++;
        if (o_data !== 9'h000) begin n_fail++; $display("FAIL match_clr: got %h exp 000", o_data); end
        bus(0, 0, 0, '0, '0); step();
    endtask

    task automatic test_timer_atomic();
        do_reset();
        for (int i = 0; i < 3000 && m_cyc < 2044; i++) step();
        bus(1, 0, 1, 11'h7F4, '0); step();
        n_tests++;
        if (o_data !== 9'h1FF) begin n_fail++; $display("FAIL tmr_lo: got %h exp 1ff", o_data); end
        bus(0, 0, 0, '0, '0);
        for (int i = 0; i < 10 && m_cyc < 2049; i++) step();
        bus(1, 0, 1, 11'h7F5, '0); step();
        n_tests++;
        if (o_data !== 9'h000 || o_data !== m_data)
            begin n_fail++; $display("FAIL tmr_hi_shadow: got %h exp 000", o_data); end
        bus(1, 0, 1, 11'h7F4, '0); step();
        bus(1, 0, 1, 11'h7F5, '0); step();
        n_tests++;
        if (o_data !== 9'h001) begin n_fail++; $display("FAIL tmr_hi_reload: got %h exp 001", o_data); end
        bus(0, 0, 0, '0, '0); step();
    endtask

    task automatic test_async_reset_sw();
        bus(1, 1, 0, 11'h7F0, 9'h0F0); step();
        bus(1, 1, 0, 11'h7F0, 9'h155);
        #3 rst = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if (o_led !== 8'h99) begin n_fail++; $display("FAIL async_reset_led: got %h exp 99", o_led); end
        step();
        bus(0, 0, 0, '0, '0);
        rst = 1'b1;
        step();
        n_tests++;
        if (o_led !== 8'h99) begin n_fail++; $display("FAIL no_partial_write: got %h exp 99", o_led); end
        sw = 8'h3C; step(); step();
        bus(1, 0, 1, 11'h7F1, '0); step();
        n_tests++;
        if (o_data !== 9'h03C || o_data !== m_data)
            begin n_fail++; $display("FAIL sw_sync: got %h exp 03c", o_data); end
        bus(0, 0, 0, '0, '0); step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_led();
        test_btn_evt();
        test_rw_same();
        test_back_to_back();
        test_random();
        test_match();
        test_timer_atomic();
        test_async_reset_sw();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
